// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selection constants
// and the baud divisor helper used by transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int bit_period(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick_out is high on the last cycle of every PERIOD-cycle
// window; clear_in holds the count at zero so a window starts on release.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned PERIOD = 10,
    parameter int unsigned WIDTH  = $clog2(PERIOD + 1)
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    output logic tick_out
);

    logic [WIDTH-1:0] count;

    if (PERIOD < 2) begin : g_bad_period
        $error("uart_baud_gen: PERIOD must be >= 2");
    end

    assign tick_out = (count == WIDTH'(PERIOD - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            count <= '0;
        end else if (tick_out) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: DATA_BITS payload LSB first, optional parity,
// 1 or 2 stop bits, one-entry holding register. Define UART_TX_BREAK_EN
// to add the break_in port and line-break generation.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
`ifdef UART_TX_BREAK_EN
    ,
    parameter int BREAK_BITS       = 13
`endif
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid_in,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_in,
`endif
    output logic                 data_ready_out,
    output logic                 busy_out,
    output logic                 tx_wire_out
);

    localparam int BAUD_BIT_PERIOD = bit_period(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W           = $clog2(STOP_BITS * BAUD_BIT_PERIOD + 1);
`ifdef UART_TX_BREAK_EN
    localparam int IDX_MAX = (BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS;
`else
    localparam int IDX_MAX = DATA_BITS;
`endif
    localparam int IDX_W = $clog2(IDX_MAX + 1);

    if (BAUD_BIT_PERIOD < 2) begin : g_bad_period
        $error("uart_tx_framed: INPUT_CLOCK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    state_t               state;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic [IDX_W-1:0]     bit_idx;
    logic                 tx_reg;
    logic                 baud_tick;
    logic                 baud_clear;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
        return (PARITY == PARITY_ODD) ? ~^word : ^word;
    endfunction

    // Counter sits at zero while idle so every frame starts on a full bit period.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .PERIOD (BAUD_BIT_PERIOD),
        .WIDTH  (CNT_W)
    ) u_baud (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (baud_clear),
        .tick_out (baud_tick)
    );

    assign data_ready_out = !hold_valid;
    assign busy_out       = (state != IDLE) || hold_valid;
    assign tx_wire_out    = tx_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            tx_reg     <= 1'b1;
        end else begin
            if (data_valid_in && !hold_valid) begin
                hold_data  <= data_in;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (break_in) begin
                        state   <= BREAK;
                        tx_reg  <= 1'b0;
                        bit_idx <= '0;
                    end else
`endif
                    if (hold_valid) begin
                        shift_reg  <= hold_data;
                        parity_bit <= frame_parity(hold_data);
                        hold_valid <= 1'b0;
                        state      <= START;
                        tx_reg     <= 1'b0;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        state     <= DATA;
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state  <= uart_pkg::PARITY;
                                tx_reg <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            tx_reg    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + IDX_W'(1);
                        end
                    end
                end

                uart_pkg::PARITY: begin
                    if (baud_tick) begin
                        state   <= STOP;
                        tx_reg  <= 1'b1;
                        bit_idx <= '0;
                    end
                end

                STOP: begin
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            // A held word goes straight into its start bit: no idle cycle.
                            if (hold_valid) begin
                                shift_reg  <= hold_data;
                                parity_bit <= frame_parity(hold_data);
                                hold_valid <= 1'b0;
                                state      <= START;
                                tx_reg     <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    // Low for BREAK_BITS periods, then one high period before IDLE.
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(BREAK_BITS)) begin
                            state  <= IDLE;
                            tx_reg <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (bit_idx == IDX_W'(BREAK_BITS - 1)) begin
                                tx_reg <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: four configurations (8N1, 8E1, 8O2, 5N1) at a
// 10-cycle bit period, checked against a bit-list frame model.
module tb_uart_tx_framed;

    localparam int P    = 10;
    localparam int NCFG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [8:0]      din;
    logic [NCFG-1:0] valid_v;
    logic [NCFG-1:0] ready_v;
    logic [NCFG-1:0] busy_v;
    logic [NCFG-1:0] tx_v;
`ifdef UART_TX_BREAK_EN
    logic [NCFG-1:0] brk_v;
`endif

    int total = 0;
    int bad   = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    function automatic int cfg_data_bits(input int s);
        return (s == 3) ? 5 : 8;
    endfunction

    function automatic int cfg_parity(input int s);
        return (s == 1) ? 2 : (s == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop_bits(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    uart_tx_framed #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_in(clk), .rst_in(rst), .data_in(din[7:0]), .data_valid_in(valid_v[0]),
`ifdef UART_TX_BREAK_EN
        .break_in(brk_v[0]),
`endif
        .data_ready_out(ready_v[0]), .busy_out(busy_v[0]), .tx_wire_out(tx_v[0]));

    uart_tx_framed #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk_in(clk), .rst_in(rst), .data_in(din[7:0]), .data_valid_in(valid_v[1]),
`ifdef UART_TX_BREAK_EN
        .break_in(brk_v[1]),
`endif
        .data_ready_out(ready_v[1]), .busy_out(busy_v[1]), .tx_wire_out(tx_v[1]));

    uart_tx_framed #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
        .clk_in(clk), .rst_in(rst), .data_in(din[7:0]), .data_valid_in(valid_v[2]),
`ifdef UART_TX_BREAK_EN
        .break_in(brk_v[2]),
`endif
        .data_ready_out(ready_v[2]), .busy_out(busy_v[2]), .tx_wire_out(tx_v[2]));

    uart_tx_framed #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .clk_in(clk), .rst_in(rst), .data_in(din[4:0]), .data_valid_in(valid_v[3]),
`ifdef UART_TX_BREAK_EN
        .break_in(brk_v[3]),
`endif
        .data_ready_out(ready_v[3]), .busy_out(busy_v[3]), .tx_wire_out(tx_v[3]));

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model frame: start, data LSB first, optional parity, stop bits.
    task automatic push_frame(input int s, input int w);
        int d;
        int ones;
        d = w & ((1 << cfg_data_bits(s)) - 1);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < cfg_data_bits(s); i++) exp_bits.push_back(bit'((d >> i) & 1));
        if (cfg_parity(s) != 0) begin
            ones = $countones(d);
            exp_bits.push_back(bit'((cfg_parity(s) == 2) ? (ones % 2) : (1 - ones % 2)));
        end
        for (int i = 0; i < cfg_stop_bits(s); i++) exp_bits.push_back(1'b1);
    endtask

    // Entered on the first low sample of a start bit; consumes exp_bits.
    task automatic check_bits(input int s);
        int ones;
        int busy_err;
        busy_err = 0;
        for (int b = 0; b < exp_bits.size(); b++) begin
            ones = 0;
            for (int c = 0; c < P; c++) begin
                if (b != 0 || c != 0) step();
                if (tx_v[s] === 1'b1) ones++;
                if (busy_v[s] !== 1'b1) busy_err++;
            end
            check_val($sformatf("cfg%0d_bit%0d", s, b), ones, exp_bits[b] ? P : 0);
        end
        check_val($sformatf("cfg%0d_busy_in_frame", s), busy_err, 0);
        exp_bits.delete();
    endtask

    task automatic wait_low(input int s, output bit ok);
        int n;
        n = 0;
        while (tx_v[s] !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        ok = (tx_v[s] === 1'b0);
        check_val($sformatf("cfg%0d_start_seen", s), int'(ok), 1);
    endtask

    task automatic end_checks(input int s);
        step();
        check_val($sformatf("cfg%0d_busy_end", s), int'(busy_v[s]), 0);
        check_val($sformatf("cfg%0d_tx_end", s), int'(tx_v[s]), 1);
        check_val($sformatf("cfg%0d_ready_end", s), int'(ready_v[s]), 1);
    endtask

    task automatic send_single(input int s, input int w);
        int lat;
        push_frame(s, w);
        check_val($sformatf("cfg%0d_ready_idle", s), int'(ready_v[s]), 1);
        din        = 9'(w);
        valid_v[s] = 1'b1;
        step();
        valid_v[s] = 1'b0;
        check_val($sformatf("cfg%0d_ready_drop", s), int'(ready_v[s]), 0);
        lat = 1;
        while (tx_v[s] !== 1'b0 && lat < 50) begin
            step();
            lat++;
        end
        check_val($sformatf("cfg%0d_latency", s), lat, 2);
        check_bits(s);
        end_checks(s);
    endtask

    // Valid held high across three words; frames must abut with no gap.
    task automatic send_burst(input int s, input int w0, input int w1, input int w2);
        int words[3];
        words = '{w0, w1, w2};
        for (int i = 0; i < 3; i++) push_frame(s, words[i]);
        fork
            begin
                bit acc;
                bit r;
                int n;
                for (int i = 0; i < 3; i++) begin
                    din        = 9'(words[i]);
                    valid_v[s] = 1'b1;
                    acc        = 1'b0;
                    n          = 0;
                    while (!acc && n < 1000) begin
                        r = ready_v[s];
                        step();
                        n++;
                        if (r) acc = 1'b1;
                    end
                    check_val($sformatf("cfg%0d_burst_accept%0d", s, i), int'(acc), 1);
                    check_val($sformatf("cfg%0d_burst_ready_drop%0d", s, i), int'(ready_v[s]), 0);
                end
                valid_v[s] = 1'b0;
            end
            begin
                bit ok;
                wait_low(s, ok);
                if (ok) check_bits(s);
                else exp_bits.delete();
            end
        join
        end_checks(s);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int busy_cnt;
        rst     = 1'b1;
        din     = '0;
        valid_v = '0;
`ifdef UART_TX_BREAK_EN
        brk_v   = '0;
`endif
        repeat (3) step();
        for (int s = 0; s < NCFG; s++) begin
            check_val($sformatf("cfg%0d_rst_tx", s), int'(tx_v[s]), 1);
            check_val($sformatf("cfg%0d_rst_busy", s), int'(busy_v[s]), 0);
            check_val($sformatf("cfg%0d_rst_ready", s), int'(ready_v[s]), 1);
        end
        rst = 1'b0;
        repeat (2) step();

        send_single(0, 'hA5);
        send_single(1, 'h07);
        send_single(2, 'h07);
        send_burst(0, 'h01, 'h02, 'h03);
        send_single(3, 'h1F);
        send_single(3, 'h3F);

        // Reset during cycle 35 of a frame while a second word is held.
        din        = 9'h05A;
        valid_v[0] = 1'b1;
        step();
        valid_v[0] = 1'b0;
        step();
        check_val("rst_frame_started", int'(tx_v[0]), 0);
        din        = 9'h03C;
        valid_v[0] = 1'b1;
        step();
        valid_v[0] = 1'b0;
        check_val("rst_word_held", int'(ready_v[0]), 0);
        repeat (33) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_mid_tx", int'(tx_v[0]), 1);
        check_val("rst_mid_busy", int'(busy_v[0]), 0);
        check_val("rst_mid_ready", int'(ready_v[0]), 1);
        lows     = 0;
        busy_cnt = 0;
        repeat (300) begin
            step();
            if (tx_v[0] !== 1'b1) lows++;
            if (busy_v[0] !== 1'b0) busy_cnt++;
        end
        check_val("rst_no_resume_low", lows, 0);
        check_val("rst_no_resume_busy", busy_cnt, 0);

`ifdef UART_TX_BREAK_EN
        begin
            int highs;
            bit ok;
            push_frame(0, 'h55);
            brk_v[0]   = 1'b1;
            din        = 9'h055;
            valid_v[0] = 1'b1;
            step();
            brk_v[0]   = 1'b0;
            valid_v[0] = 1'b0;
            lows     = 0;
            busy_cnt = 0;
            while (tx_v[0] === 1'b0 && lows < 1000) begin
                lows++;
                if (busy_v[0] !== 1'b1) busy_cnt++;
                step();
            end
            check_val("brk_low_cycles", lows, 13 * P);
            highs = 0;
            while (tx_v[0] === 1'b1 && highs < 100) begin
                highs++;
                if (busy_v[0] !== 1'b1) busy_cnt++;
                step();
            end
            // One bit period of mark, plus the IDLE cycle that launches the held word.
            check_val("brk_high_cycles", highs, P + 1);
            check_val("brk_busy", busy_cnt, 0);
            ok = (tx_v[0] === 1'b0);
            check_val("brk_frame_start", int'(ok), 1);
            if (ok) check_bits(0);
            else exp_bits.delete();
            end_checks(0);
        end
`endif

        for (int s = 0; s < NCFG; s++) begin
            repeat (3) begin
                repeat ($urandom_range(0, 5)) step();
                send_single(s, int'($urandom_range(0, 511)));
            end
            send_burst(s, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 511)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
